decode_stage: RTL



---
 rtl/riscv_pkg.sv | 59 +++++
 rtl/decode_stage_if.sv | 34 +++
 rtl/imm_gen.sv | 29 ++
 rtl/decode_stage.sv | 134 +++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/immediate encodings and the
// ID/EX pipeline register layout.
package riscv_pkg;

    localparam int unsigned RV_XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_R} imm_fmt_e;

    typedef struct packed {
        logic               valid;
        logic [RV_XLEN-1:0] pc;
        logic [RV_XLEN-1:0] rs1_data;
        logic [RV_XLEN-1:0] rs2_data;
        logic [RV_XLEN-1:0] imm;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        alu_op_e            alu_op;
        logic               alu_src;
        logic               pc_src;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               branch;
        logic               jump;
        logic [2:0]         funct3;
        logic               illegal;
    } id_ex_t;

    // alt selects SUB/SRA; callers pass 0 where the ISA has no alternate form
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// ID/EX outputs of the decode stage towards the EX stage.
interface decode_stage_if #(parameter int unsigned XLEN = 32);
    logic            ex_valid_o;
    logic [XLEN-1:0] ex_pc_o;
    logic [XLEN-1:0] ex_rs1_data_o;
    logic [XLEN-1:0] ex_rs2_data_o;
    logic [XLEN-1:0] ex_imm_o;
    logic [4:0]      ex_rs1_o;
    logic [4:0]      ex_rs2_o;
    logic [4:0]      ex_rd_o;
    logic [3:0]      ex_alu_op_o;
    logic            ex_alu_src_o;
    logic            ex_pc_src_o;
    logic            ex_mem_read_o;
    logic            ex_mem_write_o;
    logic            ex_reg_write_o;
    logic            ex_branch_o;
    logic            ex_jump_o;
    logic [2:0]      ex_funct3_o;
    logic            ex_illegal_o;

    modport master (
        output ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
               ex_rs1_o, ex_rs2_o, ex_rd_o, ex_alu_op_o, ex_alu_src_o, ex_pc_src_o,
               ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_branch_o, ex_jump_o,
               ex_funct3_o, ex_illegal_o
    );
    modport slave (
        input  ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
               ex_rs1_o, ex_rs2_o, ex_rd_o, ex_alu_op_o, ex_alu_src_o, ex_pc_src_o,
               ex_mem_read_o, ex_mem_write_o, ex_reg_write_o, ex_branch_o, ex_jump_o,
               ex_funct3_o, ex_illegal_o
    );
endinterface

// File: rtl/imm_gen.sv
// Immediate generator: extracts and sign-extends the immediate for the given
// instruction format; R-type yields zero.
module imm_gen import riscv_pkg::*; #(
    parameter int unsigned XLEN = RV_XLEN
) (
    input  logic [31:7]     instr_i,
    input  imm_fmt_e        fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt_i)
            IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            IMM_U:   imm32 = {instr_i[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control/immediate decode, WB bypass, load-use hazard
// detection and the ID/EX pipeline register.
module decode_stage import riscv_pkg::*; #(
    parameter int unsigned XLEN = RV_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [4:0]      Rs1_o,
    output logic [4:0]      Rs2_o,
    input  logic [XLEN-1:0] Read_reg1_i,
    input  logic [XLEN-1:0] Read_reg2_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            flush_i,
    output logic            stall_o,
    decode_stage_if.master  ex
);

    id_ex_t          id_ex_q, id_ex_d;
    alu_op_e         alu_op;
    imm_fmt_e        fmt;
    logic            alu_src, pc_src, mem_read, mem_write, reg_write;
    logic            branch, jump, illegal, uses_rs1, uses_rs2;
    logic [XLEN-1:0] imm, rs1_data, rs2_data;

    assign Rs1_o = instr_i[19:15];
    assign Rs2_o = instr_i[24:20];

    always_comb begin
        alu_op    = ALU_ADD;
        fmt       = IMM_R;
        alu_src   = 1'b0;
        pc_src    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        illegal   = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        case (instr_i[6:0])
            OPC_LUI:    begin fmt = IMM_U; alu_op = ALU_PASSB; alu_src = 1'b1; reg_write = 1'b1; end
            OPC_AUIPC:  begin fmt = IMM_U; pc_src = 1'b1; alu_src = 1'b1; reg_write = 1'b1; end
            OPC_JAL:    begin fmt = IMM_J; pc_src = 1'b1; alu_src = 1'b1; reg_write = 1'b1; jump = 1'b1; end
            OPC_JALR:   begin fmt = IMM_I; uses_rs1 = 1'b1; alu_src = 1'b1; reg_write = 1'b1; jump = 1'b1; end
            OPC_BRANCH: begin fmt = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1; alu_op = ALU_SUB; branch = 1'b1; end
            OPC_LOAD:   begin fmt = IMM_I; uses_rs1 = 1'b1; alu_src = 1'b1; mem_read = 1'b1; reg_write = 1'b1; end
            OPC_STORE:  begin fmt = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; alu_src = 1'b1; mem_write = 1'b1; end
            // bit 30 of OP-IMM is part of the immediate except for SRAI
            OPC_OPIMM:  begin
                fmt       = IMM_I;
                uses_rs1  = 1'b1;
                alu_src   = 1'b1;
                reg_write = 1'b1;
                alu_op    = alu_from_funct(instr_i[14:12], instr_i[30] && (instr_i[14:12] == 3'b101));
            end
            OPC_OP:     begin
                fmt       = IMM_R;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                reg_write = 1'b1;
                alu_op    = alu_from_funct(instr_i[14:12], instr_i[30]);
            end
            default:    illegal = 1'b1;
        endcase
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (instr_i[31:7]),
        .fmt_i   (fmt),
        .imm_o   (imm)
    );

    assign rs1_data = (wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == Rs1_o)) ? wb_data_i : Read_reg1_i;
    assign rs2_data = (wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == Rs2_o)) ? wb_data_i : Read_reg2_i;

    assign stall_o = valid_i && id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != 5'd0)
                   && ((uses_rs1 && (id_ex_q.rd == Rs1_o)) || (uses_rs2 && (id_ex_q.rd == Rs2_o)))
                   && !flush_i;

    always_comb begin
        id_ex_d = '0;
        if (!flush_i && !stall_o) begin
            id_ex_d.valid     = valid_i;
            id_ex_d.pc        = pc_i;
            id_ex_d.rs1_data  = rs1_data;
            id_ex_d.rs2_data  = rs2_data;
            id_ex_d.imm       = imm;
            id_ex_d.rs1       = Rs1_o;
            id_ex_d.rs2       = Rs2_o;
            id_ex_d.rd        = reg_write ? instr_i[11:7] : 5'd0;
            id_ex_d.alu_op    = alu_op;
            id_ex_d.alu_src   = alu_src;
            id_ex_d.pc_src    = pc_src;
            id_ex_d.mem_read  = mem_read;
            id_ex_d.mem_write = mem_write;
            id_ex_d.reg_write = reg_write;
            id_ex_d.branch    = branch;
            id_ex_d.jump      = jump;
            id_ex_d.funct3    = instr_i[14:12];
            id_ex_d.illegal   = illegal;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) id_ex_q <= '0;
        else         id_ex_q <= id_ex_d;
    end

    assign ex.ex_valid_o     = id_ex_q.valid;
    assign ex.ex_pc_o        = id_ex_q.pc;
    assign ex.ex_rs1_data_o  = id_ex_q.rs1_data;
    assign ex.ex_rs2_data_o  = id_ex_q.rs2_data;
    assign ex.ex_imm_o       = id_ex_q.imm;
    assign ex.ex_rs1_o       = id_ex_q.rs1;
    assign ex.ex_rs2_o       = id_ex_q.rs2;
    assign ex.ex_rd_o        = id_ex_q.rd;
    assign ex.ex_alu_op_o    = id_ex_q.alu_op;
    assign ex.ex_alu_src_o   = id_ex_q.alu_src;
    assign ex.ex_pc_src_o    = id_ex_q.pc_src;
    assign ex.ex_mem_read_o  = id_ex_q.mem_read;
    assign ex.ex_mem_write_o = id_ex_q.mem_write;
    assign ex.ex_reg_write_o = id_ex_q.reg_write;
    assign ex.ex_branch_o    = id_ex_q.branch;
    assign ex.ex_jump_o      = id_ex_q.jump;
    assign ex.ex_funct3_o    = id_ex_q.funct3;
    assign ex.ex_illegal_o   = id_ex_q.illegal;

endmodule
